// File: rtl/adder_share_ctrl.sv
// Nibble-serial adder sequencer: two requesters share a single 4-bit adder slice.
// Operands are captured in IDLE, summed LS nibble first through a carry register,
// and the finished result is published with a done pulse tagged by requester ID.

module fourbit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module adder_share_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0,
   input  logic [4*NIBBLES-1:0]   a0,
   input  logic [4*NIBBLES-1:0]   b0,
   input  logic                   cin0,
   input  logic                   req1,
   input  logic [4*NIBBLES-1:0]   a1,
   input  logic [4*NIBBLES-1:0]   b1,
   input  logic                   cin1,
   output logic                   gnt0,
   output logic                   gnt1,
   output logic                   busy,
   output logic                   done,
   output logic                   done_id,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
);

   localparam int W = 4 * NIBBLES;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;

   logic           ptr;
   logic           owner;
   logic           carry;
   logic [2:0]     idx;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [W-1:0]   res_reg;

   logic [3:0]     nib_sum;
   logic           nib_cout;
   logic [W+3:0]   res_shift;
   logic           last_nib;
   logic           any_req;
   logic           win;

   fourbit_adder slice (
      .a    (a_reg[3:0]),
      .b    (b_reg[3:0]),
      .cin  (carry),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // the new nibble enters at the top while the partial result slides down
   assign res_shift = {nib_sum, res_reg};
   assign last_nib  = (idx == 3'(NIBBLES - 1));
   assign any_req   = req0 | req1;
   assign win       = (req0 & req1) ? ptr : req1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; gnt is decoded from the first RUN cycle, done from DONE
   always_comb begin
      state_next = state;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (idx == 3'd0) begin
               gnt0 = ~owner;
               gnt1 = owner;
            end
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture and arbitration in IDLE, nibble shifting in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= 1'b0;
         owner   <= 1'b0;
         carry   <= 1'b0;
         idx     <= 3'd0;
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         done_id <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  a_reg <= win ? a1 : a0;
                  b_reg <= win ? b1 : b0;
                  carry <= win ? cin1 : cin0;
                  idx   <= 3'd0;
                  owner <= win;
                  ptr   <= ~win;
               end
            end
            RUN: begin
               res_reg <= res_shift[W+3:4];
               carry   <= nib_cout;
               a_reg   <= a_reg >> 4;
               b_reg   <= b_reg >> 4;
               idx     <= idx + 3'd1;
               if (last_nib) begin
                  sum     <= res_shift[W+3:4];
                  cout    <= nib_cout;
                  done_id <= owner;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: transaction-timeline model of the
// NIBBLES=4 instance checked every cycle, directed cases with literal results,
// and two extra instances (NIBBLES=1 and 8) driven with random operands.

module tb_adder_share_ctrl;

   localparam int NB = 4;
   localparam int W  = 4 * NB;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req0, req1, cin0, cin1;
   logic [W-1:0]   a0, b0, a1, b1;
   logic           gnt0, gnt1, busy, done, done_id, cout;
   logic [W-1:0]   sum;

   int             checks = 0;
   int             errors = 0;
   int             sweeps_finished = 0;

   // Clock generation
   always #5 clk = ~clk;

   adder_share_ctrl #(.NIBBLES(NB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .a0      (a0),
      .b0      (b0),
      .cin0    (cin0),
      .req1    (req1),
      .a1      (a1),
      .b1      (b1),
      .cin1    (cin1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .sum     (sum),
      .cout    (cout)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: one operation occupies edges cap..cap+NB+1; result lands at cap+NB
   int             e = 0;
   int             cap = -100;
   bit             m_owner = 1'b0;
   bit             m_ptr = 1'b0;
   bit             m_id = 1'b0;
   logic [W:0]     pend = '0;
   logic [W:0]     m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap   = -100;
         m_ptr = 1'b0;
         m_id  = 1'b0;
         m_res = '0;
      end else begin
         e++;
         if (e >= cap + NB + 2 && (req0 || req1)) begin
            m_owner = (req0 && req1) ? m_ptr : req1;
            m_ptr   = !m_owner;
            if (m_owner)
               pend = (W+1)'(a1) + (W+1)'(b1) + (W+1)'(cin1);
            else
               pend = (W+1)'(a0) + (W+1)'(b0) + (W+1)'(cin0);
            cap = e;
         end else if (e == cap + NB) begin
            m_res = pend;
            m_id  = m_owner;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      checkOutput("gnt0", 64'(gnt0), 64'(e == cap && !m_owner));
      checkOutput("gnt1", 64'(gnt1), 64'(e == cap && m_owner));
      checkOutput("busy", 64'(busy), 64'(e >= cap && e <= cap + NB));
      checkOutput("done", 64'(done), 64'(e == cap + NB));
      checkOutput("sum", 64'(sum), 64'(m_res[W-1:0]));
      checkOutput("cout", 64'(cout), 64'(m_res[W]));
      checkOutput("done_id", 64'(done_id), 64'(m_id));
   end

   task automatic applyStimulus(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      if (who) begin
         req1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      end else begin
         req0 = 1'b1; a0 = a; b0 = b; cin0 = c;
      end
   endtask

   task automatic waitGnt(output int at, output bit who);
      bit ok;
      ok = 1'b0; at = 0; who = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            ok = 1'b1; at = e; who = gnt1;
            break;
         end
      end
      checkOutput("gnt_timeout", 64'(ok), 64'(1));
   endtask

   task automatic waitDone(output int at);
      bit ok;
      ok = 1'b0; at = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1; at = e;
            break;
         end
      end
      checkOutput("done_timeout", 64'(ok), 64'(1));
   endtask

   // NIBBLES=1 and NIBBLES=8 instances with their own reset and random operands
   for (genvar g = 0; g < 2; g++) begin : sweep
      localparam int SN = (g == 0) ? 1 : 8;
      localparam int SW = 4 * SN;

      logic          s_rst_n, s_req, s_cin;
      logic [SW-1:0] s_a, s_b, s_sum;
      logic          s_gnt0, s_gnt1, s_busy, s_done, s_id, s_cout;

      adder_share_ctrl #(.NIBBLES(SN)) dut_s (
         .clk     (clk),
         .rst_n   (s_rst_n),
         .req0    (s_req),
         .a0      (s_a),
         .b0      (s_b),
         .cin0    (s_cin),
         .req1    (1'b0),
         .a1      ({SW{1'b0}}),
         .b1      ({SW{1'b0}}),
         .cin1    (1'b0),
         .gnt0    (s_gnt0),
         .gnt1    (s_gnt1),
         .busy    (s_busy),
         .done    (s_done),
         .done_id (s_id),
         .sum     (s_sum),
         .cout    (s_cout)
      );

      initial begin
         logic [SW:0] exp;
         int          n;
         bit          ok;
         s_rst_n = 1'b0; s_req = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
         repeat (3) @(negedge clk);
         #2 s_rst_n = 1'b1;
         for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            s_a = SW'($urandom); s_b = SW'($urandom); s_cin = 1'($urandom); s_req = 1'b1;
            exp = (SW+1)'(s_a) + (SW+1)'(s_b) + (SW+1)'(s_cin);
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               if (s_gnt0) begin ok = 1'b1; break; end
            end
            checkOutput($sformatf("sweep%0d_gnt", SN), 64'(ok), 64'(1));
            s_req = 1'b0;
            n = 0; ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               n++;
               if (s_done) begin ok = 1'b1; break; end
            end
            checkOutput($sformatf("sweep%0d_latency", SN), 64'(n), 64'(SN));
            checkOutput($sformatf("sweep%0d_sum", SN), 64'(s_sum), 64'(exp[SW-1:0]));
            checkOutput($sformatf("sweep%0d_cout", SN), 64'(s_cout), 64'(exp[SW]));
            checkOutput($sformatf("sweep%0d_id", SN), 64'(s_id), 64'(0));
         end
         sweeps_finished++;
      end
   end

   // Directed scenarios followed by a random request phase
   initial begin
      int  tg, td, prev, cnt;
      bit  who;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] single request");
      @(negedge clk);
      applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0);
      waitGnt(tg, who);
      req0 = 1'b0;
      checkOutput("t1_who", 64'(who), 64'(0));
      waitDone(td);
      checkOutput("t1_latency", 64'(td - tg), 64'(4));
      checkOutput("t1_sum", 64'(sum), 64'h5555);
      checkOutput("t1_cout", 64'(cout), 64'(0));
      checkOutput("t1_id", 64'(done_id), 64'(0));

      $display("[TB] carry ripple");
      applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      waitGnt(tg, who);
      req1 = 1'b0;
      waitDone(td);
      checkOutput("t2_sum", 64'(sum), 64'h0000);
      checkOutput("t2_cout", 64'(cout), 64'(1));
      checkOutput("t2_id", 64'(done_id), 64'(1));
      applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0);
      waitGnt(tg, who);
      req0 = 1'b0;
      waitDone(td);
      checkOutput("t3_sum", 64'(sum), 64'h0000);
      checkOutput("t3_cout", 64'(cout), 64'(1));

      $display("[TB] operand corruption after grant");
      applyStimulus(1'b0, 16'h1357, 16'h2468, 1'b1);
      waitGnt(tg, who);
      req0 = 1'b0;
      @(negedge clk);
      a0 = 16'hFFFF; b0 = 16'hFFFF;
      waitDone(td);
      checkOutput("t4_sum", 64'(sum), 64'h37C0);
      checkOutput("t4_cout", 64'(cout), 64'(0));

      $display("[TB] contention");
      @(negedge clk);
      #2 rst_n = 1'b0;
      applyStimulus(1'b0, 16'h0101, 16'h0202, 1'b0);
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         waitGnt(tg, who);
         checkOutput($sformatf("t5_order%0d", k), 64'(who), 64'(k % 2));
         if (k > 0) checkOutput($sformatf("t5_spacing%0d", k), 64'(tg - prev), 64'(6));
         prev = tg;
         waitDone(td);
         checkOutput($sformatf("t5_id%0d", k), 64'(done_id), 64'(k % 2));
         checkOutput($sformatf("t5_sum%0d", k), 64'(sum), (k % 2 == 0) ? 64'h0303 : 64'h3334);
      end
      req0 = 1'b0; req1 = 1'b0;

      $display("[TB] reset mid-operation");
      @(negedge clk);
      applyStimulus(1'b0, 16'hAAAA, 16'h5555, 1'b1);
      waitGnt(tg, who);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_gnt0", 64'(gnt0), 64'(0));
      checkOutput("t6_gnt1", 64'(gnt1), 64'(0));
      checkOutput("t6_busy", 64'(busy), 64'(0));
      checkOutput("t6_done", 64'(done), 64'(0));
      checkOutput("t6_id", 64'(done_id), 64'(0));
      checkOutput("t6_sum", 64'(sum), 64'(0));
      checkOutput("t6_cout", 64'(cout), 64'(0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      checkOutput("t6_no_done", 64'(cnt), 64'(0));
      applyStimulus(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
      waitGnt(tg, who);
      req1 = 1'b0;
      checkOutput("t6_who", 64'(who), 64'(1));
      waitDone(td);
      checkOutput("t6_sum_after", 64'(sum), 64'h1000);
      checkOutput("t6_id_after", 64'(done_id), 64'(1));

      $display("[TB] random requests");
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (gnt0 || !req0) begin
            req0 = ($urandom_range(0, 2) == 0);
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
         end
         if (gnt1 || !req1) begin
            req1 = ($urandom_range(0, 2) == 0);
            a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
         end
      end
      req0 = 1'b0; req1 = 1'b0;

      for (int i = 0; i < 2000 && sweeps_finished < 2; i++) @(negedge clk);
      checkOutput("sweeps_finished", 64'(sweeps_finished), 64'(2));
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
